// File: rtl/load_store_unit.sv
// Load/store unit: turns core byte/half/word accesses into whole-word memory
// cycles (read-modify-write for sub-word stores). Optional: LSU_BOUNDS_CHECK_EN.
module load_store_unit #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] MemAddress,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

`ifdef LSU_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        logic bad;
        case (sz)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lo[0];
            2'b10:   bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] data,
                                               input logic [1:0] sz, input logic [1:0] lo);
        logic [31:0] merged;
        merged = word;
        case (sz)
            2'b00:   merged[{lo, 3'b000} +: 8] = data[7:0];
            2'b01:   merged[{lo[1], 4'b0000} +: 16] = data[15:0];
            default: merged = data;
        endcase
        return merged;
    endfunction

    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic [1:0] lo, input logic sx);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] result;
        lane_b = word[{lo, 3'b000} +: 8];
        lane_h = word[{lo[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   result = {{24{sx & lane_b[7]}}, lane_b};
            2'b01:   result = {{16{sx & lane_h[15]}}, lane_h};
            default: result = word;
        endcase
        return result;
    endfunction

    state_t      state_r, state_s;
    logic        we_r, sign_ext_r;
    logic [1:0]  size_r, addr_lo_r;
    logic [31:0] wdata_r;
    logic        busy_r, done_r, err_r, mem_read_r, mem_write_r;
    logic [31:0] rdata_r, mem_address_r, write_data_r;
    logic        accept_s, reject_s;

    assign accept_s = (state_r == S_IDLE) && req;
    assign reject_s = is_misaligned(size, addr[1:0]) | (BOUNDS_EN & (addr >= MEM_LIMIT));

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!req) begin
                    state_s = S_IDLE;
                end else if (reject_s) begin
                    state_s = S_ERR;
                end else if (!we) begin
                    state_s = S_READ;
                end else if (size == 2'b10) begin
                    state_s = S_WRITE;
                end else begin
                    state_s = S_READ;
                end
            end
            S_READ: begin
                if (we_r) begin
                    state_s = S_WRITE;
                end else begin
                    state_s = S_DONE;
                end
            end
            S_WRITE: state_s = S_DONE;
            S_DONE:  state_s = S_IDLE;
            S_ERR:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request fields captured at acceptance; live inputs are ignored afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r       <= 1'b0;
            size_r     <= 2'b00;
            sign_ext_r <= 1'b0;
            addr_lo_r  <= 2'b00;
            wdata_r    <= 32'd0;
        end else if (accept_s) begin
            we_r       <= we;
            size_r     <= size;
            sign_ext_r <= sign_ext;
            addr_lo_r  <= addr[1:0];
            wdata_r    <= wdata;
        end
    end

    // Outputs are registered from the next state so they coincide with it;
    // async reset drops MemWrite at once so no partial write can commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            rdata_r       <= 32'd0;
            mem_address_r <= 32'd0;
            write_data_r  <= 32'd0;
        end else begin
            busy_r      <= (state_s != S_IDLE);
            done_r      <= (state_s == S_DONE) || (state_s == S_ERR);
            err_r       <= (state_s == S_ERR);
            mem_read_r  <= (state_s == S_READ);
            mem_write_r <= (state_s == S_WRITE);
            if (accept_s) begin
                mem_address_r <= {addr[31:2], 2'b00};
            end
            // The READ->WRITE edge merges the freshly read word with the store lane
            if ((state_r == S_IDLE) && (state_s == S_WRITE)) begin
                write_data_r <= wdata;
            end else if ((state_r == S_READ) && (state_s == S_WRITE)) begin
                write_data_r <= merge_lane(ReadData, wdata_r, size_r, addr_lo_r);
            end
            if ((state_r == S_READ) && (state_s == S_DONE)) begin
                rdata_r <= extract_lane(ReadData, size_r, addr_lo_r, sign_ext_r);
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign rdata      = rdata_r;
    assign MemRead    = mem_read_r;
    assign MemWrite   = mem_write_r;
    assign MemAddress = mem_address_r;
    assign WriteData  = write_data_r;

endmodule
